capsense_csd_measure_ch_multi: RTL



---
 rtl/capsense_csd_measure_ch_multi_if.sv | 27 ++
 rtl/capsense_csd_measure_ch_multi.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/capsense_csd_measure_ch_multi_if.sv
// Bus between the CSD measurement channel and its controller: measurement
// requests and sense inputs one way, counts and status the other.
interface capsense_csd_measure_ch_multi_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 20
);
    logic                 enable;
    logic                 start;
    logic                 pulse;
    logic                 cmp_in;
    logic [WIDTH-1:0]     window_period;
    logic                 ioff;
    logic [ACC_WIDTH-1:0] result;
    logic                 overflow;
    logic                 busy;
    logic                 interrupt;

    modport master (
        output enable, start, pulse, cmp_in, window_period,
        input  ioff, result, overflow, busy, interrupt
    );

    modport slave (
        input  enable, start, pulse, cmp_in, window_period,
        output ioff, result, overflow, busy, interrupt
    );
endinterface

// File: rtl/capsense_csd_measure_ch_multi.sv
// CSD measurement channel: counts "IDAC off" sense pulses over NUM_SCANS back-to-back
// windows and accumulates them into a saturating result, then raises interrupt.
module capsense_csd_measure_ch_multi #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_SCANS = 4,
    parameter int unsigned ACC_WIDTH = 20,
    parameter int unsigned IDAC_OPT  = 1
) (
    input logic clock,
    input logic reset_n,
    capsense_csd_measure_ch_multi_if.slave bus
);
    localparam int unsigned ScanW = (NUM_SCANS > 1) ? $clog2(NUM_SCANS) : 1;
    localparam logic [ScanW-1:0]     LastScan = ScanW'(NUM_SCANS - 1);
    localparam logic [WIDTH-1:0]     WinOne   = WIDTH'(1);
    localparam logic [WIDTH-1:0]     RawMax   = {WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] AccMax   = {ACC_WIDTH{1'b1}};

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StS1      = 3'd2;
    localparam logic [2:0] StCount   = 3'd3;
    localparam logic [2:0] StScanEnd = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [WIDTH-1:0]     window_q, window_d;
    logic [WIDTH-1:0]     raw_q, raw_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ScanW-1:0]     scan_q, scan_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 sync1_q, sync2_q, cmp_smp_q, ioff_q;

    logic                 cmp_pol;
    logic                 cnt_active;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;

    assign cmp_pol    = (IDAC_OPT == 2) ? ~bus.cmp_in : bus.cmp_in;
    assign cnt_active = ~cmp_smp_q;

    // One spare bit catches the carry that signals accumulator saturation.
    assign acc_sum  = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, raw_q};
    assign acc_next = acc_sum[ACC_WIDTH] ? AccMax : acc_sum[ACC_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        window_d   = window_q;
        raw_d      = raw_q;
        acc_d      = acc_q;
        scan_d     = scan_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        if (bus.enable) begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d    = StLoad;
                        acc_d      = '0;
                        scan_d     = '0;
                        overflow_d = 1'b0;
                    end
                end
                StLoad: begin
                    if (!bus.start) begin
                        state_d = StIdle;
                    end else begin
                        window_d = (bus.window_period == '0) ? WinOne : bus.window_period;
                        raw_d    = '0;
                        state_d  = StS1;
                    end
                end
                StS1: begin
                    if (!bus.start) begin
                        state_d = StIdle;
                    end else if (bus.pulse) begin
                        state_d = StCount;
                    end
                end
                StCount: begin
                    if (!bus.start) begin
                        state_d = StIdle;
                    end else begin
                        window_d = window_q - WinOne;
                        if (cnt_active) begin
                            if (raw_q == RawMax) begin
                                overflow_d = 1'b1;
                            end else begin
                                raw_d = raw_q + WinOne;
                            end
                        end
                        state_d = (window_q == WinOne) ? StScanEnd : StS1;
                    end
                end
                StScanEnd: begin
                    if (!bus.start) begin
                        state_d = StIdle;
                    end else begin
                        acc_d = acc_next;
                        if (acc_sum[ACC_WIDTH]) begin
                            overflow_d = 1'b1;
                        end
                        if (scan_q == LastScan) begin
                            result_d = acc_next;
                            state_d  = StDone;
                        end else begin
                            scan_d  = scan_q + 1'b1;
                            state_d = StLoad;
                        end
                    end
                end
                StDone: begin
                    if (!bus.start) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            window_q   <= '0;
            raw_q      <= '0;
            acc_q      <= '0;
            scan_q     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cmp_smp_q  <= 1'b0;
            ioff_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            raw_q      <= raw_d;
            acc_q      <= acc_d;
            scan_q     <= scan_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            if (bus.enable) begin
                sync1_q <= cmp_pol;
                sync2_q <= sync1_q;
                // ioff is registered alongside the sample so it reads 0 out of reset.
                if (bus.pulse) begin
                    cmp_smp_q <= sync2_q;
                    ioff_q    <= (IDAC_OPT == 0) ? sync2_q : ~sync2_q;
                end
            end
        end
    end

    assign bus.ioff      = ioff_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = (state_q == StLoad) || (state_q == StS1) ||
                           (state_q == StCount) || (state_q == StScanEnd);
    assign bus.interrupt = (state_q == StDone);
endmodule
